// File: rtl/matrix_3x3_gen.sv
// Sliding 3x3 window generator over a raster 8-bit pixel stream (two line buffers, per-row taps).
// Latency 1 cycle from accepting edge; define MATRIX_OUT_REG_EN for an extra output stage (2 cycles).
// No backpressure: one window per accepted beat once rows 0..1 and cols 0..1 have been seen.
module matrix_3x3_gen #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_vld,
    input  logic [7:0] in_data,
    output logic       mat_vld,
    output logic [7:0] mat_p11,
    output logic [7:0] mat_p12,
    output logic [7:0] mat_p13,
    output logic [7:0] mat_p21,
    output logic [7:0] mat_p22,
    output logic [7:0] mat_p23,
    output logic [7:0] mat_p31,
    output logic [7:0] mat_p32,
    output logic [7:0] mat_p33
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [7:0]    lb1 [IMG_W];
    logic [7:0]    lb2 [IMG_W];
    logic [7:0]    lb1_rd;
    logic [7:0]    lb2_rd;
    logic          win_ok;
    logic          win_vld;
    logic [7:0]    t11, t12, t13, t21, t22, t23, t31, t32, t33;

    assign lb1_rd = lb1[col];
    assign lb2_rd = lb2[col];
    assign win_ok = (row >= RW'(2)) && (col >= CW'(2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (in_vld) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Not reset: stale contents are never exposed because rows 0..1 mask every window.
    always_ff @(posedge clk) begin
        if (in_vld) begin
            lb1[col] <= in_data;
            lb2[col] <= lb1_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_vld <= 1'b0;
            t11 <= '0; t12 <= '0; t13 <= '0;
            t21 <= '0; t22 <= '0; t23 <= '0;
            t31 <= '0; t32 <= '0; t33 <= '0;
        end else begin
            win_vld <= in_vld && win_ok;
            if (in_vld) begin
                t11 <= t12; t12 <= t13; t13 <= lb2_rd;
                t21 <= t22; t22 <= t23; t23 <= lb1_rd;
                t31 <= t32; t32 <= t33; t33 <= in_data;
            end
        end
    end

`ifdef MATRIX_OUT_REG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mat_vld <= 1'b0;
            mat_p11 <= '0; mat_p12 <= '0; mat_p13 <= '0;
            mat_p21 <= '0; mat_p22 <= '0; mat_p23 <= '0;
            mat_p31 <= '0; mat_p32 <= '0; mat_p33 <= '0;
        end else begin
            mat_vld <= win_vld;
            mat_p11 <= t11; mat_p12 <= t12; mat_p13 <= t13;
            mat_p21 <= t21; mat_p22 <= t22; mat_p23 <= t23;
            mat_p31 <= t31; mat_p32 <= t32; mat_p33 <= t33;
        end
    end
`else
    assign mat_vld = win_vld;
    assign mat_p11 = t11;
    assign mat_p12 = t12;
    assign mat_p13 = t13;
    assign mat_p21 = t21;
    assign mat_p22 = t22;
    assign mat_p23 = t23;
    assign mat_p31 = t31;
    assign mat_p32 = t32;
    assign mat_p33 = t33;
`endif

endmodule

// File: tb/tb_matrix_3x3_gen.sv
// Bench for matrix_3x3_gen: a 4x4 and a 5x5 instance checked against a frame-array window model.
module tb_matrix_3x3_gen;
`ifdef MATRIX_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct packed {
        logic [31:0]     cyc;
        logic [8:0][7:0] p;
    } win_t;

    typedef struct packed {
        logic [31:0]     beat;
        logic [8:0][7:0] p;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic v4 = 1'b0, v5 = 1'b0;
    logic [7:0] d4 = '0, d5 = '0;
    logic o4_vld, o5_vld;
    logic [8:0][7:0] o4, o5;
    int cyc = 0;
    int checks = 0;
    int failures = 0;

    win_t obs [2][$];
    win_t exp_q [2][$];
    int   mr [2];
    int   mc [2];
    int   dim [2] = '{4, 5};
    logic [7:0] img [2][8][8];
    vec_t tbl [4];
    win_t mw4, mw5;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    matrix_3x3_gen #(.IMG_W(4), .IMG_H(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_vld(v4), .in_data(d4), .mat_vld(o4_vld),
        .mat_p11(o4[0]), .mat_p12(o4[1]), .mat_p13(o4[2]),
        .mat_p21(o4[3]), .mat_p22(o4[4]), .mat_p23(o4[5]),
        .mat_p31(o4[6]), .mat_p32(o4[7]), .mat_p33(o4[8])
    );

    matrix_3x3_gen #(.IMG_W(5), .IMG_H(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_vld(v5), .in_data(d5), .mat_vld(o5_vld),
        .mat_p11(o5[0]), .mat_p12(o5[1]), .mat_p13(o5[2]),
        .mat_p21(o5[3]), .mat_p22(o5[4]), .mat_p23(o5[5]),
        .mat_p31(o5[6]), .mat_p32(o5[7]), .mat_p33(o5[8])
    );

    always @(negedge clk) begin
        if (rst_n) begin
            if (o4_vld) begin
                mw4.cyc = cyc;
                mw4.p   = o4;
                obs[0].push_back(mw4);
            end
            if (o5_vld) begin
                mw5.cyc = cyc;
                mw5.p   = o5;
                obs[1].push_back(mw5);
            end
        end
    end

    function automatic logic [8:0][7:0] w9(input int a, b, c, d, e, f, g, h, i);
        logic [8:0][7:0] r;
        r[0] = a[7:0]; r[1] = b[7:0]; r[2] = c[7:0];
        r[3] = d[7:0]; r[4] = e[7:0]; r[5] = f[7:0];
        r[6] = g[7:0]; r[7] = h[7:0]; r[8] = i[7:0];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, " vld4"}, {71'd0, o4_vld}, 72'd0);
        chk({nm, " pix4"}, o4, 72'd0);
        chk({nm, " vld5"}, {71'd0, o5_vld}, 72'd0);
        chk({nm, " pix5"}, o5, 72'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            v4 = 1'b0;
            v5 = 1'b0;
        end
    endtask

    // Model: store the pixel at its frame position; a window exists when it has two rows and two columns above/left.
    task automatic beat(input int d, input logic [7:0] val);
        win_t e;
        @(posedge clk);
        #1;
        v4 = 1'b0;
        v5 = 1'b0;
        if (d == 0) begin v4 = 1'b1; d4 = val; end
        else        begin v5 = 1'b1; d5 = val; end
        img[d][mr[d]][mc[d]] = val;
        if (mr[d] >= 2 && mc[d] >= 2) begin
            e.cyc = cyc + LAT;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    e.p[r*3+c] = img[d][mr[d]-2+r][mc[d]-2+c];
            exp_q[d].push_back(e);
        end
        mc[d]++;
        if (mc[d] == dim[d]) begin
            mc[d] = 0;
            mr[d]++;
            if (mr[d] == dim[d]) mr[d] = 0;
        end
    endtask

    task automatic check_phase(input int d, input string nm);
        int n;
        chk({nm, " count"}, obs[d].size(), exp_q[d].size());
        n = (obs[d].size() < exp_q[d].size()) ? obs[d].size() : exp_q[d].size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s win%0d cycle", nm, i), obs[d][i].cyc, exp_q[d][i].cyc);
            chk($sformatf("%s win%0d pix", nm, i), obs[d][i].p, exp_q[d][i].p);
        end
        obs[d].delete();
        exp_q[d].delete();
    endtask

    task automatic tbl_check(input int k0, input bit use_cyc, input string nm);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s tbl%0d present", nm, i), {71'd0, obs[0].size() > i}, 72'd1);
            if (obs[0].size() > i) begin
                chk($sformatf("%s tbl%0d pix", nm, i), obs[0][i].p, tbl[i].p);
                if (use_cyc)
                    chk($sformatf("%s tbl%0d cycle", nm, i), obs[0][i].cyc,
                        k0 + tbl[i].beat - 1 + LAT);
            end
        end
    endtask

    task automatic basic_frame(input string nm);
        int k0 = 0;
        for (int i = 0; i < 16; i++) begin
            beat(0, i[7:0]);
            if (i == 0) k0 = cyc;
        end
        idle(LAT + 3);
        tbl_check(k0, 1'b1, nm);
        check_phase(0, nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k0;
        tbl[0].beat = 11; tbl[0].p = w9(0, 1, 2, 4, 5, 6, 8, 9, 10);
        tbl[1].beat = 12; tbl[1].p = w9(1, 2, 3, 5, 6, 7, 9, 10, 11);
        tbl[2].beat = 15; tbl[2].p = w9(4, 5, 6, 8, 9, 10, 12, 13, 14);
        tbl[3].beat = 16; tbl[3].p = w9(5, 6, 7, 9, 10, 11, 13, 14, 15);
        for (int d = 0; d < 2; d++) begin mr[d] = 0; mc[d] = 0; end

        repeat (2) @(negedge clk);
        chk_zero("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        basic_frame("basic");

        for (int i = 0; i < 16; i++) begin
            beat(0, i[7:0]);
            if (i % 2 == 1) idle(3);
        end
        idle(LAT + 3);
        tbl_check(0, 1'b0, "gaps");
        check_phase(0, "gaps");

        for (int i = 0; i < 25; i++) beat(1, i[7:0]);
        idle(LAT + 3);
        chk("wrap5 row3 present", {71'd0, obs[1].size() > 3}, 72'd1);
        if (obs[1].size() > 3) begin
            chk("wrap5 row3 p11", obs[1][3].p[0], 72'd5);
            chk("wrap5 row3 p31", obs[1][3].p[6], 72'd15);
        end
        check_phase(1, "wrap5");

        k0 = 0;
        for (int i = 0; i < 32; i++) begin
            beat(0, (i < 16) ? i[7:0] : 8'(i - 16 + 100));
            if (i == 0) k0 = cyc;
        end
        idle(LAT + 3);
        chk("frame2 first present", {71'd0, obs[0].size() > 4}, 72'd1);
        if (obs[0].size() > 4) begin
            chk("frame2 first cycle", obs[0][4].cyc, k0 + 26 + LAT);
            chk("frame2 first p11", obs[0][4].p[0], 72'd100);
            chk("frame2 first p33", obs[0][4].p[8], 72'd110);
        end
        check_phase(0, "framewrap");

        for (int i = 0; i < 10; i++) beat(0, i[7:0]);
        idle(LAT + 3);
        check_phase(0, "prerst");
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk_zero("midrst");
        repeat (2) begin
            @(negedge clk);
            chk_zero("midrst hold");
        end
        for (int d = 0; d < 2; d++) begin mr[d] = 0; mc[d] = 0; end
        @(posedge clk);
        #1 rst_n = 1'b1;
        basic_frame("postrst");

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 2 * dim[d] * dim[d]; i++) begin
                beat(d, 8'($urandom_range(0, 255)));
                if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
            end
            idle(LAT + 3);
            check_phase(d, $sformatf("rand%0d", d));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/matrix_3x3_gen.md
# matrix_3x3_gen

Generates a sliding 3x3 pixel window from a raster-order 8-bit grayscale stream. It supplies the nine neighbourhood pixels, three per row, to the downstream three-input sorters and the median/min/max filter stage of the face-detection pipeline. Internally it uses two line buffers and per-row tap registers, so one window is produced per accepted pixel once two full rows and two columns have been seen.

## Interface
- IMG_W, 640, active pixels per line (>= 3)
- IMG_H, 480, active lines per frame (>= 3)

- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_vld  input  1  input pixel valid; one pixel accepted per cycle when high
- in_data  input  8  input pixel, raster order, frame starts at (row 0, col 0)
- mat_vld  output  1  window valid, single-cycle pulse per window
- mat_p11, mat_p12, mat_p13  output  8 each  top (oldest) row, left to right
- mat_p21, mat_p22, mat_p23  output  8 each  middle row, left to right
- mat_p31, mat_p32, mat_p33  output  8 each  bottom (current) row, left to right

## Operation
- Counters col (0..IMG_W-1) and row (0..IMG_H-1) advance only on accepted beats (in_vld=1).
  - At col=IMG_W-1: col->0, row+1.
  - At col=IMG_W-1 and row=IMG_H-1: col->0, row->0. The next beat is frame start.
- Line buffers lb1 and lb2, each IMG_W x 8, are indexed by col. On an accepted beat:
  - read lb1[col] and lb2[col] (old values);
  - write lb1[col]<=in_data and lb2[col]<=old lb1[col].
  - Read-before-write at the same address is required.
- Row taps on an accepted beat:
  - bottom row shifts in in_data;
  - middle row shifts in old lb1[col];
  - top row shifts in old lb2[col].
  - Shift order: p*1<=p*2, p*2<=p*3, p*3<=new.
- Window valid condition: row>=2 and col>=2 for the accepted beat. The window then covers rows row-2..row and cols col-2..col.
- Windows straddling a line or frame boundary are never flagged valid. Stale tap and line-buffer contents need no clearing.
- in_vld=0: counters, taps and line buffers hold; mat_vld=0; mat_p* hold their last values.
- Valid windows per frame: exactly (IMG_W-2)*(IMG_H-2).
- Line-buffer arrays are not reset. All valid windows are masked until rows 0 and 1 of the current frame have been written.
- Arithmetic: col and row use $clog2(IMG_W) and $clog2(IMG_H) bits, unsigned compare.

## Timing
- Reset values: mat_vld=0, all mat_p*=8'd0, col=0, row=0, taps=0.
- Reset asserted mid-frame: outputs clear immediately. The first beat after release is treated as (row 0, col 0).
- Latency without OUT_REG_EN: mat_vld and mat_p* appear in the cycle after the accepting edge, i.e. 1 cycle.
- Back-to-back in_vld gives back-to-back windows. No backpressure: the downstream stage must accept every mat_vld.
- mat_p* are stable while mat_vld=1. Their values when mat_vld=0 are undefined for consumers.

## Configuration
- MATRIX_OUT_REG_EN
  - Defined: adds a second register stage on mat_vld and all mat_p*, for a total latency of 2 cycles. Output reset values are unchanged.
  - Undefined: latency is 1 cycle as above.
- Window contents and valid count are identical in both builds.

## Test plan
- Basic window: IMG_W=4, IMG_H=4, pixel value = row*4+col, continuous in_vld.
  - First mat_vld occurs after the 11th beat (row 2, col 2).
  - Required window: p11..p13=0,1,2; p21..p23=4,5,6; p31..p33=8,9,10.
  - Exactly 4 pulses per frame; the last window is p11=5, p33=15.
- Gaps: same image with in_vld low for 3 cycles after every 2nd beat. Window values and count must be identical to the continuous case, and mat_vld must be 0 during gaps.
- Line wrap: IMG_W=5. Check that no mat_vld fires for the col=0 and col=1 beats of rows >= 2. The first window of row 3 has p11=5, p31=15.
- Frame wrap: two consecutive 4x4 frames, frame 2 with value+100.
  - Frame 2 must produce no window until its 11th beat.
  - That window is p11=100, p33=110, with no frame-1 data present.
- Reset mid-frame: assert rst_n low at row 2, col 1. All outputs must read 0 while reset is low. After release, a full frame must yield windows exactly as in the basic test.
- MATRIX_OUT_REG_EN build: rerun the basic test. Every pulse must be delayed by exactly one cycle with identical values.
